// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - command FIFO feeding a combinational FPU, one registered result at a time
module fpu_op_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_op,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic        fpu_control,
   input  logic [31:0] fpu_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_op,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t        state, state_nxt;
   logic [64:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [64:0]   head;
   logic          empty, push, pop;

   assign empty    = (count == '0);
   assign in_ready = (count < DEPTH_C);
   assign push     = in_valid && in_ready;
   assign pop      = (state == EXEC);
   assign head     = mem[rd_ptr];

   // Stale storage is masked whenever the queue is empty.
   assign fpu_a       = empty ? 32'd0 : head[64:33];
   assign fpu_b       = empty ? 32'd0 : head[32:1];
   assign fpu_control = empty ? 1'b0  : head[0];

   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_a, in_b, in_op};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out_result <= 32'd0;
         out_op     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            out_result <= fpu_result;
            out_op     <= head[0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (!empty) state_nxt = EXEC;
         EXEC: state_nxt = DONE;
         // A push landing on the handshake edge counts as pending work.
         DONE: if (out_ready) state_nxt = (!empty || push) ? EXEC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule
